uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
AXI4-lite master that drives the AXI_UART slave register port and unloads received bytes into the embedded memory through a simple synchronous write port.
- On an initialize request it resets the UART FIFOs, then polls STAT and pops RX bytes.
- It packs bytes little-endian into MEMORY_DATA_WIDTH words and writes LOAD_WORDS consecutive words from address 0.
- It fills the currently unused master side of the UART/RAM top level.

Parameters:
C_M_AXI_ADDR_WIDTH, 4, AXI-lite address width (UART Lite map: 0x0 RX, 0x4 TX, 0x8 STAT, 0xC CTRL)
C_M_AXI_DATA_WIDTH, 32, AXI-lite data width
MEMORY_ADDR_WIDTH, 18, memory word-address width
MEMORY_DATA_WIDTH, 16, memory word width; multiple of 8; BPW = MEMORY_DATA_WIDTH/8
LOAD_WORDS, 2**MEMORY_ADDR_WIDTH, words loaded per session (1..2**MEMORY_ADDR_WIDTH)

Ports:
clk  in  1  single clock, all logic on rising edge
resetn  in  1  asynchronous, active-low reset
UART_initialize  in  1  level; sampled high in IDLE/DONE starts a session
M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  C_M_AXI_DATA_WIDTH  write data
M_AXI_WSTB  out  C_M_AXI_DATA_WIDTH/8  write strobes, all ones
M_AXI_WAVLID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read valid
M_AXI_RREADY  out  1  read ready
mem_addr  out  MEMORY_ADDR_WIDTH  memory word address
mem_wdata  out  MEMORY_DATA_WIDTH  memory write data
mem_we  out  1  one-cycle write strobe
busy  out  1  session in progress
done  out  1  LOAD_WORDS written; held until next session start
err  out  4  sticky {bresp/rresp!=OKAY, parity, frame, overrun}; cleared at session start

Behaviour:
- Reset values: all VALIDs, BREADY, RREADY, mem_we, busy, done = 0; addresses, data, mem_addr, err = 0; M_AXI_WSTB = all ones. Reset mid-session aborts immediately with no completion of the outstanding transaction; the next session restarts from mem_addr 0.
- FSM: IDLE, INIT_W, INIT_B, POLL_A, POLL_R, POP_A, POP_R, WRITE, DONE.
- IDLE/DONE: when UART_initialize=1, go to INIT_W; clear done, err, byte index and word counter; busy=1. UART_initialize is ignored in all other states.
- INIT_W: AWADDR=0xC and WDATA=0x3 (reset TX+RX FIFOs); AWVALID and WAVLID rise together. Each valid drops independently on its own handshake. Leave the state when both handshakes are done, in either order or the same cycle.
- INIT_B: BREADY=1; on BVALID, BRESP!=0 sets err[3]; go to POLL_A.
- POLL_A: ARADDR=0x8, ARVALID=1 until ARREADY; then POLL_R.
- POLL_R: RREADY=1; on RVALID:
  - err[2:0] |= RDATA[7:5]; RRESP!=0 sets err[3].
  - Next state is POP_A if RDATA[0]=1, else POLL_A.
- POP_A: ARADDR=0x0; same handshake as POLL_A; then POP_R.
- POP_R: RREADY=1; on RVALID, RDATA[7:0] goes to lane [8*idx+7:8*idx] of the pack register; RRESP!=0 sets err[3].
  - If idx==BPW-1: idx=0, go to WRITE.
  - Else idx+1, go to POLL_A.
- WRITE: mem_we=1 for exactly one cycle; mem_addr=word counter; mem_wdata=pack register.
  - If counter==LOAD_WORDS-1: go to DONE with done=1 and busy=0; counter does not wrap.
  - Else counter+1, go to POLL_A.
- AXI rules:
  - One transaction outstanding at a time.
  - VALID never depends combinationally on READY; address and data are registered and stable while VALID=1.
  - READY seen in the same cycle VALID first rises is a valid handshake.
  - BREADY/RREADY are high only in INIT_B/POLL_R/POP_R.
  - The AW/W/B channels are used only in INIT; no TX writes.
- Errors do not stop the load; bytes are stored as received.
- Zero-wait slave latency: 4 cycles per byte (POLL_A, POLL_R, POP_A, POP_R) plus 1 WRITE cycle per word.

Test Plan:
- Init, zero-wait slave: assert UART_initialize 1 cycle -> one write of AWADDR=0xC, WDATA=0x3, WSTB=0xF; busy=1 from next cycle; BREADY high until BVALID.
- Delayed handshakes: AWREADY in cycle 3, WREADY in cycle 1 -> WAVLID drops after cycle 1, AWVALID held with stable address until cycle 3, exactly one write.
- Byte packing: STAT=0x01, RX bytes 0x34 then 0x12 -> mem_we pulse with mem_addr=0, mem_wdata=0x1234; next word at mem_addr=1.
- Empty polling: STAT returns 0x00 three times, then 0x01 -> three extra STAT reads, no read of 0x0 issued until STAT bit0=1.
- Completion and errors: LOAD_WORDS=2, second STAT=0x41, one RRESP=2'b10 -> done=1, busy=0 after the second write; err=4'b1010; UART_initialize while busy is ignored.
- Reset mid-pop: resetn low during POP_R -> all outputs at reset values asynchronously; new session writes from mem_addr=0.

Source files
------------

// File: rtl/uart_mem_loader.sv
`timescale 1ns/1ps
// AXI4-lite master that resets the UART Lite FIFOs, drains RX bytes and
// packs them little-endian into memory words written from address 0.
module uart_mem_loader #(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int MEMORY_ADDR_WIDTH  = 18,
   parameter int MEMORY_DATA_WIDTH  = 16,
   parameter int LOAD_WORDS         = 2**MEMORY_ADDR_WIDTH
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            UART_initialize,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTB,
   output logic                            M_AXI_WAVLID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY,
   output logic [MEMORY_ADDR_WIDTH-1:0]    mem_addr,
   output logic [MEMORY_DATA_WIDTH-1:0]    mem_wdata,
   output logic                            mem_we,
   output logic                            busy,
   output logic                            done,
   output logic [3:0]                      err
);

   localparam int AW  = C_M_AXI_ADDR_WIDTH;
   localparam int DW  = C_M_AXI_DATA_WIDTH;
   localparam int MAW = MEMORY_ADDR_WIDTH;
   localparam int MDW = MEMORY_DATA_WIDTH;
   localparam int BPW = MDW / 8;
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

   localparam logic [AW-1:0]  A_RX     = AW'(0);
   localparam logic [AW-1:0]  A_STAT   = AW'(8);
   localparam logic [AW-1:0]  A_CTRL   = AW'(12);
   localparam logic [DW-1:0]  D_FIFORST = DW'(3);
   localparam logic [IW-1:0]  IDX_LAST = IW'(BPW - 1);
   localparam logic [MAW-1:0] CNT_LAST = MAW'(LOAD_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT_W,
      S_INIT_B,
      S_POLL_A,
      S_POLL_R,
      S_POP_A,
      S_POP_R,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_awaddr;
   logic            r_awvalid;
   logic [DW-1:0]   r_wdata;
   logic            r_wvalid;
   logic            r_bready;
   logic [AW-1:0]   r_araddr;
   logic            r_arvalid;
   logic            r_rready;
   logic [MAW-1:0]  r_mem_addr;
   logic [MDW-1:0]  r_mem_wdata;
   logic            r_mem_we;
   logic            r_busy;
   logic            r_done;
   logic [3:0]      r_err;
   logic [IW-1:0]   r_idx;
   logic [MAW-1:0]  r_cnt;
   logic [MDW-1:0]  r_pack;

   logic            w_aw_ok;
   logic            w_w_ok;
   logic            w_rresp_err;
   logic            w_bresp_err;
   logic [MDW-1:0]  w_pack_nxt;
   logic            w_unused;

   // A channel is finished once its valid is gone or handshakes this cycle.
   assign w_aw_ok     = !r_awvalid || M_AXI_AWREADY;
   assign w_w_ok      = !r_wvalid  || M_AXI_WREADY;
   assign w_rresp_err = |M_AXI_RRESP;
   assign w_bresp_err = |M_AXI_BRESP;
   assign w_unused    = ^{M_AXI_RDATA[DW-1:8], M_AXI_RDATA[4:1]};

   always_comb begin
      w_pack_nxt = r_pack;
      for (int i = 0; i < BPW; i++) begin
         if (r_idx == IW'(i)) w_pack_nxt[8*i +: 8] = M_AXI_RDATA[7:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_awaddr    <= '0;
         r_awvalid   <= 1'b0;
         r_wdata     <= '0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_araddr    <= '0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= '0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_pack      <= '0;
      end else begin
         r_mem_we <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (UART_initialize) begin
                  r_state   <= S_INIT_W;
                  r_awaddr  <= A_CTRL;
                  r_wdata   <= D_FIFORST;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_err     <= '0;
                  r_idx     <= '0;
                  r_cnt     <= '0;
               end
            end
            S_INIT_W: begin
               if (M_AXI_AWREADY) r_awvalid <= 1'b0;
               if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
               if (w_aw_ok && w_w_ok) begin
                  r_state  <= S_INIT_B;
                  r_bready <= 1'b1;
               end
            end
            S_INIT_B: begin
               if (M_AXI_BVALID) begin
                  r_bready  <= 1'b0;
                  r_err[3]  <= r_err[3] | w_bresp_err;
                  r_state   <= S_POLL_A;
                  r_araddr  <= A_STAT;
                  r_arvalid <= 1'b1;
               end
            end
            S_POLL_A: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_POLL_R;
               end
            end
            S_POLL_R: begin
               if (M_AXI_RVALID) begin
                  r_rready  <= 1'b0;
                  r_err     <= r_err | {w_rresp_err, M_AXI_RDATA[7:5]};
                  r_arvalid <= 1'b1;
                  if (M_AXI_RDATA[0]) begin
                     r_araddr <= A_RX;
                     r_state  <= S_POP_A;
                  end else begin
                     r_araddr <= A_STAT;
                     r_state  <= S_POLL_A;
                  end
               end
            end
            S_POP_A: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_POP_R;
               end
            end
            S_POP_R: begin
               if (M_AXI_RVALID) begin
                  r_rready <= 1'b0;
                  r_err[3] <= r_err[3] | w_rresp_err;
                  r_pack   <= w_pack_nxt;
                  if (r_idx == IDX_LAST) begin
                     r_idx       <= '0;
                     r_state     <= S_WRITE;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_cnt;
                     r_mem_wdata <= w_pack_nxt;
                  end else begin
                     r_idx     <= r_idx + 1'b1;
                     r_state   <= S_POLL_A;
                     r_araddr  <= A_STAT;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
                  r_state   <= S_POLL_A;
                  r_araddr  <= A_STAT;
                  r_arvalid <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTB    = '1;
   assign M_AXI_WAVLID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_araddr;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign mem_we        = r_mem_we;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;

endmodule

// File: tb/tb_uart_mem_loader.sv
`timescale 1ns/1ps
// Directed bench for uart_mem_loader: UART Lite slave model, load-session
// vector table, plus delayed-handshake and mid-pop reset sequences.
module tb_uart_mem_loader;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        UART_initialize = 1'b0;
   logic [3:0]  M_AXI_AWADDR;
   logic        M_AXI_AWVALID;
   logic        M_AXI_AWREADY = 1'b0;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTB;
   logic        M_AXI_WAVLID;
   logic        M_AXI_WREADY = 1'b0;
   logic [1:0]  M_AXI_BRESP = 2'b00;
   logic        M_AXI_BVALID = 1'b0;
   logic        M_AXI_BREADY;
   logic [3:0]  M_AXI_ARADDR;
   logic        M_AXI_ARVALID;
   logic        M_AXI_ARREADY = 1'b0;
   logic [31:0] M_AXI_RDATA = '0;
   logic [1:0]  M_AXI_RRESP = 2'b00;
   logic        M_AXI_RVALID = 1'b0;
   logic        M_AXI_RREADY;
   logic [3:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic [3:0]  err;

   uart_mem_loader #(
      .C_M_AXI_ADDR_WIDTH(4),
      .C_M_AXI_DATA_WIDTH(32),
      .MEMORY_ADDR_WIDTH(4),
      .MEMORY_DATA_WIDTH(16),
      .LOAD_WORDS(2)
   ) dut (
      .clk(clk), .resetn(resetn), .UART_initialize(UART_initialize),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
      .M_AXI_WSTB(M_AXI_WSTB), .M_AXI_WAVLID(M_AXI_WAVLID),
      .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
      .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  n_empty;
      logic [7:0]  stat2;
      logic [31:0] rx;
      logic [7:0]  rresp;
      logic        poke;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [3:0]  err;
   } vec_t;

   vec_t vt[4];

   int n_checks = 0;
   int n_errors = 0;

   // slave stimulus, written between sessions
   logic [7:0] stat_mem[16];
   int         stat_n = 0;
   logic [9:0] rx_mem[4];
   int         aw_dly = 0, w_dly = 0, b_dly = 0;

   // posedge monitor
   bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
   logic [3:0]  hs_ar_addr;
   bit          prev_busy = 1'b0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [3:0]  aw_addr_seen;
   logic [31:0] wdata_seen;
   logic [3:0]  wstb_seen;
   logic [3:0]  ar_log[$];
   logic [19:0] wr_log[$];

   always @(posedge clk) begin
      if (busy && !prev_busy) begin
         ar_log.delete();
         wr_log.delete();
         aw_cnt = 0;
         w_cnt  = 0;
         b_cnt  = 0;
      end
      prev_busy  = busy;
      hs_aw      = M_AXI_AWVALID && M_AXI_AWREADY;
      hs_w       = M_AXI_WAVLID && M_AXI_WREADY;
      hs_b       = M_AXI_BVALID && M_AXI_BREADY;
      hs_ar      = M_AXI_ARVALID && M_AXI_ARREADY;
      hs_r       = M_AXI_RVALID && M_AXI_RREADY;
      hs_ar_addr = M_AXI_ARADDR;
      if (hs_aw) begin
         aw_cnt++;
         aw_addr_seen = M_AXI_AWADDR;
      end
      if (hs_w) begin
         w_cnt++;
         wdata_seen = M_AXI_WDATA;
         wstb_seen  = M_AXI_WSTB;
      end
      if (hs_b) b_cnt++;
      if (hs_ar) ar_log.push_back(M_AXI_ARADDR);
      if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
   end

   // UART Lite slave: drives inputs on the falling edge
   int         aw_wait = 0, w_wait = 0, b_wait = 0, sp = 0, rp = 0;
   bit         ar_pend = 1'b0;
   logic [3:0] ar_a = '0;

   always @(negedge clk) begin
      if (!resetn) begin
         M_AXI_AWREADY = 1'b0;
         M_AXI_WREADY  = 1'b0;
         M_AXI_BVALID  = 1'b0;
         M_AXI_ARREADY = 1'b0;
         M_AXI_RVALID  = 1'b0;
         ar_pend = 1'b0;
         aw_wait = 0;
         w_wait  = 0;
         b_wait  = 0;
      end else begin
         if (M_AXI_AWVALID) begin
            sp = 0;
            rp = 0;
            M_AXI_AWREADY = (aw_wait >= aw_dly);
            aw_wait++;
         end else begin
            M_AXI_AWREADY = 1'b0;
            aw_wait = 0;
         end
         if (M_AXI_WAVLID) begin
            M_AXI_WREADY = (w_wait >= w_dly);
            w_wait++;
         end else begin
            M_AXI_WREADY = 1'b0;
            w_wait = 0;
         end
         if (M_AXI_BVALID && hs_b) M_AXI_BVALID = 1'b0;
         if (M_AXI_BREADY && !M_AXI_BVALID) begin
            if (b_wait >= b_dly) M_AXI_BVALID = 1'b1;
            else b_wait++;
         end else begin
            b_wait = 0;
         end
         M_AXI_ARREADY = 1'b1;
         if (M_AXI_RVALID && hs_r) M_AXI_RVALID = 1'b0;
         if (hs_ar) begin
            ar_pend = 1'b1;
            ar_a = hs_ar_addr;
         end
         if (ar_pend && !M_AXI_RVALID) begin
            M_AXI_RVALID = 1'b1;
            ar_pend = 1'b0;
            if (ar_a == 4'h8) begin
               M_AXI_RDATA = {24'h0, (sp < stat_n) ? stat_mem[sp] : 8'h01};
               M_AXI_RRESP = 2'b00;
               sp++;
            end else begin
               M_AXI_RDATA = {24'h0, (rp < 4) ? rx_mem[rp][7:0] : 8'h00};
               M_AXI_RRESP = (rp < 4) ? rx_mem[rp][9:8] : 2'b00;
               rp++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, 64'({M_AXI_AWVALID, M_AXI_WAVLID, M_AXI_BREADY,
          M_AXI_ARVALID, M_AXI_RREADY, mem_we, busy, done}), 64'h0);
      chk({tag, "_addr"}, 64'({M_AXI_AWADDR, M_AXI_ARADDR, mem_addr, err}),
          64'h0);
      chk({tag, "_data"}, 64'({M_AXI_WDATA, mem_wdata}), 64'h0);
      chk({tag, "_wstb"}, 64'(M_AXI_WSTB), 64'hF);
   endtask

   task automatic load_stim(input vec_t v);
      int k = 0;
      for (int i = 0; i < int'(v.n_empty); i++) begin
         stat_mem[k] = 8'h00;
         k++;
      end
      stat_mem[k] = 8'h01;   k++;
      stat_mem[k] = v.stat2; k++;
      stat_mem[k] = 8'h01;   k++;
      stat_mem[k] = 8'h01;   k++;
      stat_n = k;
      for (int i = 0; i < 4; i++) rx_mem[i] = {v.rresp[2*i +: 2], v.rx[8*i +: 8]};
   endtask

   task automatic start_session(input string tag);
      @(negedge clk);
      UART_initialize = 1'b1;
      @(negedge clk);
      UART_initialize = 1'b0;
      chk({tag, "_start"}, 64'({busy, done, M_AXI_AWVALID, M_AXI_WAVLID}),
          64'b1011);
   endtask

   task automatic run_session(input string tag, input bit poke);
      bit seen = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         UART_initialize = poke && (c == 10 || c == 11);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      UART_initialize = 1'b0;
      chk({tag, "_done"}, 64'(seen), 64'h1);
   endtask

   task automatic check_session(input vec_t v, input string tag);
      logic [3:0]  exp_q[$];
      int          bad = 0;
      logic [19:0] w0, w1;
      w0 = (wr_log.size() > 0) ? wr_log[0] : 20'hFFFFF;
      w1 = (wr_log.size() > 1) ? wr_log[1] : 20'hFFFFF;
      chk({tag, "_busy"},  64'(busy), 64'h0);
      chk({tag, "_nwr"},   64'(wr_log.size()), 64'd2);
      chk({tag, "_wr0"},   64'(w0), 64'({4'd0, v.w0}));
      chk({tag, "_wr1"},   64'(w1), 64'({4'd1, v.w1}));
      chk({tag, "_err"},   64'(err), 64'(v.err));
      chk({tag, "_nhs"},   64'({aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}),
          64'h010101);
      chk({tag, "_init"},  64'({aw_addr_seen, wdata_seen, wstb_seen}),
          64'({4'hC, 32'h3, 4'hF}));
      for (int k = 0; k < int'(v.n_empty); k++) exp_q.push_back(4'h8);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(4'h8);
         exp_q.push_back(4'h0);
      end
      chk({tag, "_nar"}, 64'(ar_log.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < ar_log.size(); k++)
         if (ar_log[k] !== exp_q[k]) bad++;
      chk({tag, "_arseq"}, 64'(bad), 64'h0);
   endtask

   initial begin
      bit found = 1'b0;
      vt[0] = '{n_empty: 4'd0, stat2: 8'h01, rx: 32'h5678_1234, rresp: 8'h00,
                poke: 1'b0, w0: 16'h1234, w1: 16'h5678, err: 4'b0000};
      vt[1] = '{n_empty: 4'd3, stat2: 8'h01, rx: 32'h01EF_CDAB, rresp: 8'h00,
                poke: 1'b0, w0: 16'hCDAB, w1: 16'h01EF, err: 4'b0000};
      vt[2] = '{n_empty: 4'd0, stat2: 8'h41, rx: 32'h4433_2211, rresp: 8'h20,
                poke: 1'b1, w0: 16'h2211, w1: 16'h4433, err: 4'b1010};
      vt[3] = '{n_empty: 4'd1, stat2: 8'hA1, rx: 32'h7F80_00FF, rresp: 8'h00,
                poke: 1'b0, w0: 16'h00FF, w1: 16'h7F80, err: 4'b0101};

      #2 resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         load_stim(vt[i]);
         start_session($sformatf("v%0d", i));
         run_session($sformatf("v%0d", i), vt[i].poke);
         check_session(vt[i], $sformatf("v%0d", i));
      end

      // AWREADY in cycle 3, WREADY in cycle 1, BVALID one cycle late
      aw_dly = 2;
      w_dly  = 0;
      b_dly  = 1;
      load_stim(vt[0]);
      start_session("dly");
      @(negedge clk);
      chk("dly_c2", 64'({M_AXI_AWVALID, M_AXI_WAVLID, M_AXI_AWADDR}), 64'h2C);
      @(negedge clk);
      chk("dly_c3", 64'({M_AXI_AWVALID, M_AXI_WAVLID, M_AXI_AWADDR}), 64'h2C);
      @(negedge clk);
      chk("dly_c4", 64'({M_AXI_AWVALID, M_AXI_WAVLID, M_AXI_BREADY}), 64'h1);
      @(negedge clk);
      chk("dly_bwait", 64'(M_AXI_BREADY), 64'h1);
      @(negedge clk);
      chk("dly_poll", 64'({M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARADDR}),
          64'h18);
      run_session("dly", 1'b0);
      check_session(vt[0], "dly");
      aw_dly = 0;
      b_dly  = 0;

      // reset while waiting for an RX byte
      load_stim(vt[2]);
      start_session("mp");
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (M_AXI_RREADY && M_AXI_ARADDR == 4'h0) begin
            found = 1'b1;
            break;
         end
      end
      chk("mp_popr", 64'(found), 64'h1);
      #1 resetn = 1'b0;
      #1 chk_reset("mp");
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      load_stim(vt[1]);
      start_session("post");
      run_session("post", 1'b0);
      check_session(vt[1], "post");

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not end by itself");
      $fatal(1);
   end

endmodule
